// File: rtl/tim_gp_pkg.sv
// Shared constants for the general-purpose timer: mode encoding and default widths.
package tim_gp_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_PSC_W = 16;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_CENTRE = 2'd2,
    MODE_RSVD   = 2'd3
  } tim_mode_e;

endpackage

// File: rtl/tim_gp_psc.sv
// Prescaler: issues one tick every i_psc+1 enabled clocks; clr restarts the period.
module tim_gp_psc #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] i_psc,
  output logic             tick
);

  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

  logic [PSC_W-1:0] cnt_q;

  // >= rather than == so a prescale value lowered mid-period cannot run the count past it
  assign tick = en && (cnt_q >= i_psc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + PSC_ONE;
    end
  end

endmodule

// File: rtl/tim_gp_cnt.sv
// General-purpose up/down/centre-aligned timer with shadowed auto-reload and one-pulse mode.
// Define TIM_GP_RCR_EN to add the repetition counter (input i_rcr) gating uev.
module tim_gp_cnt
  import tim_gp_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PSC_W = DEF_PSC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_en,
  input  logic             ld_cnt,
  input  logic [CNT_W-1:0] i_data_cnt,
  input  logic [1:0]       mode,
  input  logic             opm,
  input  logic             arr_wr,
  input  logic [CNT_W-1:0] i_arr,
  input  logic [PSC_W-1:0] i_psc,
`ifdef TIM_GP_RCR_EN
  input  logic [7:0]       i_rcr,
`endif
  output logic [CNT_W-1:0] o_cnt,
  output logic             dir,
  output logic             cnt_ov,
  output logic             cnt_uv,
  output logic             uev,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tim_mode_e        mode_sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] arr_act, arr_pend;
  logic             dir_q, dir_d;
  logic             ov_d, uv_d, uev_d;
  logic             stop_q;
  logic             tick;

  assign mode_sel = tim_mode_e'(mode);
  assign busy     = timer_en & ~stop_q & ~rst;
  assign o_cnt    = cnt_q;
  assign dir      = dir_q;

  tim_gp_psc #(
    .PSC_W (PSC_W)
  ) u_psc (
    .clk   (clk),
    .rst   (rst),
    .en    (busy),
    .clr   (ld_cnt),
    .i_psc (i_psc),
    .tick  (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    ov_d  = 1'b0;
    uv_d  = 1'b0;
    if (ld_cnt) begin
      cnt_d = i_data_cnt;
    end else if (tick) begin
      case (mode_sel)
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (cnt_q == '0) begin
            cnt_d = arr_act;
            uv_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        MODE_CENTRE: begin
          if (cnt_q > arr_act) begin
            // loaded above the reload value: walk back down into range
            cnt_d = cnt_q - CNT_ONE;
            dir_d = 1'b0;
          end else if (arr_act == '0) begin
            cnt_d = '0;
            ov_d  = 1'b1;
          end else if (dir_q) begin
            if (cnt_q == arr_act) begin
              cnt_d = arr_act - CNT_ONE;
              dir_d = 1'b0;
              ov_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            if (cnt_q == '0) begin
              cnt_d = CNT_ONE;
              dir_d = 1'b1;
              uv_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          dir_d = 1'b1;
          if ((cnt_q == arr_act) || (cnt_q == '1)) begin
            cnt_d = '0;
            ov_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef TIM_GP_RCR_EN
  logic [7:0] rep_q;

  assign uev_d = (ov_d | uv_d) && (rep_q == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= 8'd0;
    end else if (ov_d | uv_d) begin
      rep_q <= (rep_q == 8'd0) ? i_rcr : rep_q - 8'd1;
    end
  end
`else
  assign uev_d = ov_d | uv_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      dir_q    <= 1'b1;
      arr_act  <= '1;
      arr_pend <= '1;
      cnt_ov   <= 1'b0;
      cnt_uv   <= 1'b0;
      uev      <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      cnt_ov <= ov_d;
      cnt_uv <= uv_d;
      uev    <= uev_d;
      if (arr_wr) begin
        arr_pend <= i_arr;
      end
      // the wrap on this edge still uses the old reload value
      if (uev_d || !busy) begin
        arr_act <= arr_pend;
      end
      if (!timer_en) begin
        stop_q <= 1'b0;
      end else if (opm && uev_d) begin
        stop_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tim_gp_cnt.sv
// Directed bench for tim_gp_cnt: expected per-cycle outputs are queued, then popped and compared.
module tb_tim_gp_cnt;
  import tim_gp_pkg::*;

  localparam int CNT_W = 16;
  localparam int PSC_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             timer_en;
  logic             ld_cnt;
  logic [CNT_W-1:0] i_data_cnt;
  logic [1:0]       mode;
  logic             opm;
  logic             arr_wr;
  logic [CNT_W-1:0] i_arr;
  logic [PSC_W-1:0] i_psc;
`ifdef TIM_GP_RCR_EN
  logic [7:0]       i_rcr;
`endif
  logic [CNT_W-1:0] o_cnt;
  logic             dir;
  logic             cnt_ov;
  logic             cnt_uv;
  logic             uev;
  logic             busy;

  always #5 clk = ~clk;

  tim_gp_cnt #(
    .CNT_W (CNT_W),
    .PSC_W (PSC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .timer_en   (timer_en),
    .ld_cnt     (ld_cnt),
    .i_data_cnt (i_data_cnt),
    .mode       (mode),
    .opm        (opm),
    .arr_wr     (arr_wr),
    .i_arr      (i_arr),
    .i_psc      (i_psc),
`ifdef TIM_GP_RCR_EN
    .i_rcr      (i_rcr),
`endif
    .o_cnt      (o_cnt),
    .dir        (dir),
    .cnt_ov     (cnt_ov),
    .cnt_uv     (cnt_uv),
    .uev        (uev),
    .busy       (busy)
  );

  typedef struct {
    string tag;
    int    cnt;
    int    ov;
    int    uv;
    int    ev;
    int    dr;
    int    bsy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int c, input int ov, input int uv,
                      input int ev, input int dr, input int bsy);
    exp_t e;
    e.tag = tag; e.cnt = c; e.ov = ov; e.uv = uv; e.ev = ev; e.dr = dr; e.bsy = bsy;
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
      end else begin
        e = sb.pop_front();
        chk({e.tag, ".cnt"},  32'(o_cnt),  32'(e.cnt));
        chk({e.tag, ".ov"},   32'(cnt_ov), 32'(e.ov));
        chk({e.tag, ".uv"},   32'(cnt_uv), 32'(e.uv));
        chk({e.tag, ".uev"},  32'(uev),    32'(e.ev));
        chk({e.tag, ".dir"},  32'(dir),    32'(e.dr));
        chk({e.tag, ".busy"}, 32'(busy),   32'(e.bsy));
      end
    end
  endtask

  initial begin
    rst = 1'b1; timer_en = 1'b1; ld_cnt = 1'b0; i_data_cnt = '0; mode = MODE_UP;
    opm = 1'b0; arr_wr = 1'b0; i_arr = '0; i_psc = '0;
`ifdef TIM_GP_RCR_EN
    i_rcr = 8'd0;
`endif
    // reset holds everything idle even with timer_en high
    for (int i = 0; i < 3; i++) push("rst", 0, 0, 0, 0, 1, 0);
    run(3);
    rst = 1'b0; timer_en = 1'b0;

    // up mode, arr=4, psc=0
    i_arr = 16'd4; arr_wr = 1'b1;
    push("cfg_up", 0, 0, 0, 0, 1, 0); run(1);
    arr_wr = 1'b0;
    push("cfg_up", 0, 0, 0, 0, 1, 0); run(1);
    timer_en = 1'b1;
    for (int c = 1; c <= 4; c++) push("up", c, 0, 0, 0, 1, 1);
    push("up_wrap", 0, 1, 0, 1, 1, 1);
    push("up", 1, 0, 0, 0, 1, 1);
    run(6);
    timer_en = 1'b0;
    push("hold", 1, 0, 0, 0, 1, 0); run(1);

    // centre mode, arr=3
    ld_cnt = 1'b1; i_data_cnt = 16'd0; i_arr = 16'd3; arr_wr = 1'b1;
    push("ld_off", 0, 0, 0, 0, 1, 0); run(1);
    ld_cnt = 1'b0; arr_wr = 1'b0; mode = MODE_CENTRE;
    push("cfg_ctr", 0, 0, 0, 0, 1, 0); run(1);
    timer_en = 1'b1;
    push("ctr", 1, 0, 0, 0, 1, 1);
    push("ctr", 2, 0, 0, 0, 1, 1);
    push("ctr", 3, 0, 0, 0, 1, 1);
    push("ctr_top", 2, 1, 0, 1, 0, 1);
    push("ctr", 1, 0, 0, 0, 0, 1);
    push("ctr", 0, 0, 0, 0, 0, 1);
    push("ctr_bot", 1, 0, 1, 1, 1, 1);
    push("ctr", 2, 0, 0, 0, 1, 1);
    run(8);

    // down mode, arr=3, psc=1: dir follows on the first tick
    timer_en = 1'b0; ld_cnt = 1'b1; i_data_cnt = 16'd0; mode = MODE_DOWN; i_psc = 16'd1;
    push("ld_off", 0, 0, 0, 0, 1, 0); run(1);
    ld_cnt = 1'b0; timer_en = 1'b1;
    push("dn_psc", 0, 0, 0, 0, 1, 1);
    push("dn_wrap", 3, 0, 1, 1, 0, 1);
    push("dn", 3, 0, 0, 0, 0, 1);
    push("dn", 2, 0, 0, 0, 0, 1);
    push("dn", 2, 0, 0, 0, 0, 1);
    push("dn", 1, 0, 0, 0, 0, 1);
    push("dn", 1, 0, 0, 0, 0, 1);
    push("dn", 0, 0, 0, 0, 0, 1);
    push("dn", 0, 0, 0, 0, 0, 1);
    push("dn_wrap", 3, 0, 1, 1, 0, 1);
    run(10);

    // arr=0: counter pinned at 0, every tick flags
    timer_en = 1'b0; i_psc = 16'd0; mode = MODE_UP; i_arr = 16'd0; arr_wr = 1'b1;
    ld_cnt = 1'b1; i_data_cnt = 16'd0;
    push("ld_off", 0, 0, 0, 0, 0, 0); run(1);
    ld_cnt = 1'b0; arr_wr = 1'b0;
    push("cfg_z", 0, 0, 0, 0, 0, 0); run(1);
    timer_en = 1'b1;
    push("z_up", 0, 1, 0, 1, 1, 1);
    push("z_up", 0, 1, 0, 1, 1, 1);
    run(2);
    mode = MODE_DOWN;
    push("z_dn", 0, 0, 1, 1, 0, 1); run(1);

    // shadowed reload: write arr=5 at cnt=2 while wrapping at 9
    timer_en = 1'b0; mode = MODE_UP; i_arr = 16'd9; arr_wr = 1'b1;
    ld_cnt = 1'b1; i_data_cnt = 16'd0;
    push("ld_off", 0, 0, 0, 0, 0, 0); run(1);
    ld_cnt = 1'b0; arr_wr = 1'b0;
    push("cfg_sh", 0, 0, 0, 0, 0, 0); run(1);
    timer_en = 1'b1;
    push("sh", 1, 0, 0, 0, 1, 1);
    push("sh", 2, 0, 0, 0, 1, 1);
    run(2);
    i_arr = 16'd5; arr_wr = 1'b1;
    push("sh", 3, 0, 0, 0, 1, 1); run(1);
    arr_wr = 1'b0;
    for (int c = 4; c <= 9; c++) push("sh_old", c, 0, 0, 0, 1, 1);
    push("sh_wrap9", 0, 1, 0, 1, 1, 1);
    for (int c = 1; c <= 5; c++) push("sh_new", c, 0, 0, 0, 1, 1);
    push("sh_wrap5", 0, 1, 0, 1, 1, 1);
    run(13);

    // one-pulse mode, arr=2
    timer_en = 1'b0; i_arr = 16'd2; arr_wr = 1'b1; ld_cnt = 1'b1; i_data_cnt = 16'd0;
    push("ld_off", 0, 0, 0, 0, 1, 0); run(1);
    ld_cnt = 1'b0; arr_wr = 1'b0;
    push("cfg_opm", 0, 0, 0, 0, 1, 0); run(1);
    opm = 1'b1; timer_en = 1'b1;
    push("opm", 1, 0, 0, 0, 1, 1);
    push("opm", 2, 0, 0, 0, 1, 1);
    push("opm_stop", 0, 1, 0, 1, 1, 0);
    push("opm_hold", 0, 0, 0, 0, 1, 0);
    push("opm_hold", 0, 0, 0, 0, 1, 0);
    run(5);
    timer_en = 1'b0;
    push("opm_off", 0, 0, 0, 0, 1, 0); run(1);
    timer_en = 1'b1;
    push("opm_re", 1, 0, 0, 0, 1, 1);
    push("opm_re", 2, 0, 0, 0, 1, 1);
    push("opm_restop", 0, 1, 0, 1, 1, 0);
    run(3);

    // load coinciding with the wrap tick wins and suppresses the flag
    timer_en = 1'b0; opm = 1'b0;
    push("opm_clr", 0, 0, 0, 0, 1, 0); run(1);
    timer_en = 1'b1;
    push("ldt", 1, 0, 0, 0, 1, 1);
    push("ldt", 2, 0, 0, 0, 1, 1);
    run(2);
    ld_cnt = 1'b1; i_data_cnt = 16'd7;
    push("ld_tick", 7, 0, 0, 0, 1, 1); run(1);
    ld_cnt = 1'b0;
    push("above_arr", 8, 0, 0, 0, 1, 1); run(1);

`ifdef TIM_GP_RCR_EN
    // repetition counter: uev on every third overflow
    timer_en = 1'b0; i_arr = 16'd1; arr_wr = 1'b1; ld_cnt = 1'b1; i_data_cnt = 16'd0;
    i_rcr = 8'd2;
    push("ld_off", 0, 0, 0, 0, 1, 0); run(1);
    ld_cnt = 1'b0; arr_wr = 1'b0;
    push("cfg_rcr", 0, 0, 0, 0, 1, 0); run(1);
    timer_en = 1'b1;
    push("rcr", 1, 0, 0, 0, 1, 1);
    push("rcr_ev", 0, 1, 0, 1, 1, 1);
    push("rcr", 1, 0, 0, 0, 1, 1);
    push("rcr_skip", 0, 1, 0, 0, 1, 1);
    push("rcr", 1, 0, 0, 0, 1, 1);
    push("rcr_skip", 0, 1, 0, 0, 1, 1);
    push("rcr", 1, 0, 0, 0, 1, 1);
    push("rcr_ev", 0, 1, 0, 1, 1, 1);
    run(8);
`endif

    // reset mid-count aborts immediately
    timer_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async.cnt", 32'(o_cnt), 32'd0);
    chk("rst_async.busy", 32'(busy), 32'd0);
    chk("rst_async.dir", 32'(dir), 32'd1);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
